// File: rtl/ppu_reg_scheduler.sv
// Queues CPU register writes and commits them to the PPU only during vertical
// blanking, pulsing frame_done once per frame when the drain window closes.
module ppu_reg_scheduler #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned VACTIVE = 480,
  parameter int unsigned VLAST   = 524
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic [2:0]                   address,
  input  logic [31:0]                  writedata,
  input  logic [9:0]                   vcount,
  input  logic                         ppu_ready,
  output logic                         ppu_write,
  output logic [2:0]                   ppu_address,
  output logic [31:0]                  ppu_writedata,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         overflow,
  output logic                         frame_done
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned EW = 35;

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ppu_write_q, ppu_write_d;
  logic [2:0]      ppu_address_q, ppu_address_d;
  logic [31:0]     ppu_writedata_q, ppu_writedata_d;
  logic            overflow_q, overflow_d;
  logic            frame_done_q, frame_done_d;

  logic            push_req, push_ok, ctrl_wr, flush, load;
  logic [EW-1:0]   head;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    level_d         = level_q;
    ppu_write_d     = ppu_write_q;
    ppu_address_d   = ppu_address_q;
    ppu_writedata_d = ppu_writedata_q;
    overflow_d      = overflow_q;
    frame_done_d    = 1'b0;
    head            = mem_q[rd_ptr_q];

    push_req = chipselect && write && (address != 3'd7);
    ctrl_wr  = chipselect && write && (address == 3'd7);
    flush    = ctrl_wr && writedata[1];
    // Fullness is judged on the registered level, before any same-cycle pop.
    push_ok  = push_req && (level_q != LW'(DEPTH));
    load     = (state_q == DRAIN) && (level_q != '0) && (vcount != 10'(VLAST))
               && !flush && (!ppu_write_q || ppu_ready);

    if (push_req && !push_ok) overflow_d = 1'b1;
    if (ctrl_wr && writedata[0]) overflow_d = 1'b0;

    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (load)    rd_ptr_d = rd_ptr_q + PW'(1);
    level_d = level_q + LW'(push_ok) - LW'(load);
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end

    // Address and data only change on a load, so they hold during a stall.
    if (load) begin
      ppu_write_d     = 1'b1;
      ppu_address_d   = head[34:32];
      ppu_writedata_d = head[31:0];
    end else if (ppu_ready) begin
      ppu_write_d     = 1'b0;
    end

    case (state_q)
      IDLE:  if (vcount >= 10'(VACTIVE)) state_d = DRAIN;
      DRAIN: if (!ppu_write_q && ((level_q == '0) || (vcount == 10'(VLAST)))) begin
               state_d      = DONE;
               frame_done_d = 1'b1;
             end
      DONE:  if (vcount < 10'(VACTIVE)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      ppu_write_q     <= 1'b0;
      ppu_address_q   <= '0;
      ppu_writedata_q <= '0;
      overflow_q      <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      ppu_write_q     <= ppu_write_d;
      ppu_address_q   <= ppu_address_d;
      ppu_writedata_q <= ppu_writedata_d;
      overflow_q      <= overflow_d;
      frame_done_q    <= frame_done_d;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {address, writedata};
  end

  assign ppu_write     = ppu_write_q;
  assign ppu_address   = ppu_address_q;
  assign ppu_writedata = ppu_writedata_q;
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_ppu_reg_scheduler.sv
// Scenario bench for ppu_reg_scheduler: a queue model of expected commits is
// compared against the transfers observed on the PPU port.
module tb_ppu_reg_scheduler;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [9:0]  vcount = '0;
  logic        ppu_ready = 1'b1;
  logic        ppu_write;
  logic [2:0]  ppu_address;
  logic [31:0] ppu_writedata;
  logic [3:0]  level;
  logic        overflow;
  logic        frame_done;

  ppu_reg_scheduler #(.DEPTH(DEPTH), .VACTIVE(480), .VLAST(524)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata), .vcount(vcount),
    .ppu_ready(ppu_ready), .ppu_write(ppu_write), .ppu_address(ppu_address),
    .ppu_writedata(ppu_writedata), .level(level), .overflow(overflow),
    .frame_done(frame_done)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [2:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t obs_q[$];
  ent_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   fd_count = 0;

  // Advance one cycle, logging any transfer that completes on this edge.
  task automatic tick();
    if (ppu_write && ppu_ready) obs_q.push_back({ppu_address, ppu_writedata});
    @(posedge clk);
    #1;
    if (frame_done) fd_count++;
  endtask

  task automatic cpu_wr(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
  endtask

  // Queued write with random payload; the model keeps it only if room remains.
  task automatic push_rand();
    ent_t e;
    e.a = 3'($urandom_range(0, 6));
    e.d = $urandom;
    cpu_wr(e.a, e.d);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
  endtask

  task automatic run_frame(input int budget, input bit rand_ready, output bit ok);
    int start;
    start = fd_count;
    ok = 1'b0;
    vcount = 10'd480;
    for (int i = 0; i < budget; i++) begin
      if (rand_ready) ppu_ready = 1'($urandom_range(0, 1));
      tick();
      if (fd_count != start) begin
        ok = 1'b1;
        break;
      end
    end
    ppu_ready = 1'b1;
  endtask

  task automatic end_frame();
    vcount = 10'd0;
    tick();
    tick();
    vcount = 10'd100;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (ppu_write !== 1'b0) begin bad++; $display("FAIL reset_ppu_write got=%0b want=0", ppu_write); end
    total++; if (ppu_address !== 3'd0 || ppu_writedata !== 32'd0) begin bad++; $display("FAIL reset_addr_data got=%0d/%h want=0/0", ppu_address, ppu_writedata); end
    total++; if (level !== 4'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL reset_status got=%0d/%0b/%0b want=0/0/0", level, overflow, frame_done); end
    reset = 1'b0;
    vcount = 10'd100;
    tick();
  endtask

  task automatic test_basic();
    int start;
    for (int i = 0; i < 3; i++) begin
      ent_t e;
      e.a = 3'(i);
      e.d = $urandom;
      cpu_wr(e.a, e.d);
      exp_q.push_back(e);
    end
    for (int i = 0; i < 5; i++) tick();
    total++; if (level !== 4'd3 || ppu_write !== 1'b0 || obs_q.size() != 0) begin bad++; $display("FAIL basic_hold got=lvl%0d pw%0b n%0d want=lvl3 pw0 n0", level, ppu_write, obs_q.size()); end
    start = fd_count;
    vcount = 10'd480;
    tick();
    total++; if (ppu_write !== 1'b0) begin bad++; $display("FAIL basic_enter got=%0b want=0", ppu_write); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (ppu_write !== 1'b1 || ppu_address !== exp_q[i].a || ppu_writedata !== exp_q[i].d) begin bad++; $display("FAIL basic_commit%0d got=%0b/%0d/%h want=1/%0d/%h", i, ppu_write, ppu_address, ppu_writedata, exp_q[i].a, exp_q[i].d); end
    end
    tick();
    total++; if (ppu_write !== 1'b0 || fd_count != start) begin bad++; $display("FAIL basic_tail got=pw%0b fd%0d want=pw0 fd%0d", ppu_write, fd_count, start); end
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL basic_frame_done got=%0b want=1", frame_done); end
    tick();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL basic_fd_pulse got=%0b want=0", frame_done); end
    end_frame();
  endtask

  task automatic test_overflow_random();
    int n;
    bit ok;
    n = $urandom_range(9, 12);
    for (int i = 0; i < n; i++) push_rand();
    total++; if (level !== 4'(DEPTH) || overflow !== 1'b1) begin bad++; $display("FAIL ovf_full got=lvl%0d ovf%0b want=lvl%0d ovf1", level, overflow, DEPTH); end
    cpu_wr(3'd7, 32'h1);
    total++; if (level !== 4'(DEPTH) || overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=lvl%0d ovf%0b want=lvl%0d ovf0", level, overflow, DEPTH); end
    run_frame(200, 1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL ovf_drain_timeout got=no_frame_done want=frame_done"); end
    total++; if (obs_q.size() != exp_q.size() || level !== 4'd0) begin bad++; $display("FAIL ovf_drain_count got=%0d lvl%0d want=%0d lvl0", obs_q.size(), level, exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_order%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    end_frame();
  endtask

  task automatic test_stall();
    bit   ok;
    ent_t first;
    for (int i = 0; i < 3; i++) push_rand();
    first = exp_q[0];
    ppu_ready = 1'b0;
    vcount = 10'd480;
    tick();
    tick();
    total++; if (ppu_write !== 1'b1 || level !== 4'd2) begin bad++; $display("FAIL stall_load got=pw%0b lvl%0d want=pw1 lvl2", ppu_write, level); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({ppu_address, ppu_writedata} !== first || ppu_write !== 1'b1 || level !== 4'd2) begin bad++; $display("FAIL stall_hold%0d got=%h/lvl%0d want=%h/lvl2", i, {ppu_address, ppu_writedata}, level, first); end
    end
    ppu_ready = 1'b1;
    run_frame(50, 1'b0, ok);
    total++; if (!ok || obs_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_resume got=ok%0b n%0d want=ok1 n%0d", ok, obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL stall_order%0d got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    end_frame();
  endtask

  task automatic test_vlast();
    bit   ok;
    int   start;
    ent_t keep[$];
    for (int i = 0; i < DEPTH; i++) push_rand();
    keep = exp_q;
    ppu_ready = 1'b0;
    vcount = 10'd480;
    for (int i = 0; i < 3; i++) tick();
    total++; if (ppu_write !== 1'b1 || level !== 4'd7) begin bad++; $display("FAIL vlast_load got=pw%0b lvl%0d want=pw1 lvl7", ppu_write, level); end
    start = fd_count;
    vcount = 10'd524;
    tick();
    tick();
    total++; if (ppu_write !== 1'b1 || fd_count != start) begin bad++; $display("FAIL vlast_stall got=pw%0b fd%0d want=pw1 fd%0d", ppu_write, fd_count, start); end
    ppu_ready = 1'b1;
    tick();
    total++; if (ppu_write !== 1'b0 || level !== 4'd7 || obs_q.size() != 1) begin bad++; $display("FAIL vlast_no_load got=pw%0b lvl%0d n%0d want=pw0 lvl7 n1", ppu_write, level, obs_q.size()); end
    tick();
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL vlast_frame_done got=%0b want=1", frame_done); end
    end_frame();
    for (int i = 0; i < 3; i++) tick();
    total++; if (ppu_write !== 1'b0 || level !== 4'd7) begin bad++; $display("FAIL vlast_carry got=pw%0b lvl%0d want=pw0 lvl7", ppu_write, level); end
    run_frame(60, 1'b0, ok);
    total++; if (!ok || obs_q.size() != 7) begin bad++; $display("FAIL vlast_next_frame got=ok%0b n%0d want=ok1 n7", ok, obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i + 1 < keep.size(); i++) begin
      total++; if (obs_q[i] !== keep[i + 1]) begin bad++; $display("FAIL vlast_order%0d got=%h want=%h", i, obs_q[i], keep[i + 1]); end
    end
    end_frame();
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    int start;
    for (int i = 0; i < 6; i++) push_rand();
    ppu_ready = 1'b0;
    vcount = 10'd480;
    tick();
    tick();
    total++; if (level !== 4'd5 || ppu_write !== 1'b1) begin bad++; $display("FAIL rst_pre got=lvl%0d pw%0b want=lvl5 pw1", level, ppu_write); end
    reset = 1'b1;
    #1;
    total++; if (ppu_write !== 1'b0 || level !== 4'd0) begin bad++; $display("FAIL rst_async got=pw%0b lvl%0d want=pw0 lvl0", ppu_write, level); end
    tick();
    reset = 1'b0;
    vcount = 10'd0;
    ppu_ready = 1'b1;
    tick();
    tick();
    obs_q.delete();
    start = fd_count;
    run_frame(20, 1'b0, ok);
    total++; if (!ok || fd_count != start + 1 || obs_q.size() != 0) begin bad++; $display("FAIL rst_empty_frame got=ok%0b fd%0d n%0d want=ok1 fd%0d n0", ok, fd_count, obs_q.size(), start + 1); end
    end_frame();
  endtask

  task automatic test_flush();
    bit ok;
    for (int i = 0; i < 4; i++) push_rand();
    total++; if (level !== 4'd4) begin bad++; $display("FAIL flush_pre got=%0d want=4", level); end
    cpu_wr(3'd7, 32'h2);
    exp_q.delete();
    total++; if (level !== 4'd0 || overflow !== 1'b0) begin bad++; $display("FAIL flush_level got=lvl%0d ovf%0b want=lvl0 ovf0", level, overflow); end
    run_frame(20, 1'b0, ok);
    total++; if (!ok || obs_q.size() != 0) begin bad++; $display("FAIL flush_commits got=ok%0b n%0d want=ok1 n0", ok, obs_q.size()); end
    end_frame();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow_random();
    test_stall();
    test_vlast();
    test_reset_mid_drain();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
